// File: rtl/l1_refill_ctrl.sv
`timescale 1ns/1ps
// l1_refill_ctrl
//   Blocking L1 controller that sits between a CPU port, a registered cache
//   array and a memory port. Reads look up the cache and refill from memory
//   on a miss. Writes are write-through / write-allocate: the cache is
//   updated first, then the word is written to memory.
//
//   Optional feature macro: L1_REFILL_TIMEOUT_EN
//     defined   - a wait counter aborts a memory access after TIMEOUT_CYCLES
//                 cycles without m_ack and reports cpu_err with cpu_done.
//     undefined - no counter; memory waits are unbounded; cpu_err is 0.
//
//   Parameters
//     TIMEOUT_CYCLES  memory-wait cycles before abort (timeout build only)
//
//   Ports
//     clk, reset      clock, asynchronous active-high reset
//     cpu_*           CPU request/response port (cpu_ready high only in IDLE)
//     c_*             cache array port (c_rdata/c_hit valid one cycle after c_rd)
//     m_*             memory port (m_req held with stable fields until m_ack)
//     o_dbg_state     current FSM state encoding, for observation only
//
//   Handshakes: a CPU request is taken in a cycle where cpu_req=1 and
//   cpu_ready=1; requests while cpu_ready=0 are dropped, not queued. A memory
//   transfer completes in the first cycle where m_req=1 and m_ack=1; m_ack in
//   any other cycle has no effect.
module l1_refill_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_ready,
  output logic        cpu_done,
  output logic [31:0] cpu_rdata,
  output logic        cpu_err,
  output logic [31:0] c_addr,
  output logic [31:0] c_wdata,
  output logic        c_rd,
  output logic        c_wr,
  input  logic [31:0] c_rdata,
  input  logic        c_hit,
  output logic        m_req,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic        m_ack,
  input  logic [31:0] m_rdata,
  output logic [2:0]  o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOOKUP   = 3'd1,
    S_MEM_RD   = 3'd2,
    S_FILL     = 3'd3,
    S_WR_CACHE = 3'd4,
    S_MEM_WR   = 3'd5,
    S_RESP     = 3'd6
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic [31:0] r_cwdata;
  logic        w_accept;
  logic        w_mem_wait;
  logic        w_tmo;

  assign w_accept   = (r_state == S_IDLE) && cpu_req;
  assign w_mem_wait = (r_state == S_MEM_RD) || (r_state == S_MEM_WR);

`ifdef L1_REFILL_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CW-1:0] r_tmo_cnt;
  logic          r_err;

  // m_ack in the limit cycle wins: timeout only fires when m_ack is low.
  assign w_tmo = w_mem_wait && !m_ack && (r_tmo_cnt == CW'(TIMEOUT_CYCLES - 1));

  // Counter sits at zero outside the wait states, so it is clear on entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tmo_cnt <= '0;
      r_err     <= 1'b0;
    end else begin
      if (!w_mem_wait || m_ack || w_tmo) begin
        r_tmo_cnt <= '0;
      end else begin
        r_tmo_cnt <= r_tmo_cnt + CW'(1);
      end
      if (w_tmo) begin
        r_err <= 1'b1;
      end else if (r_state == S_RESP) begin
        r_err <= 1'b0;
      end
    end
  end

  assign cpu_err = (r_state == S_RESP) && r_err;
`else
  assign w_tmo   = 1'b0;
  // The parameter stays referenced so both builds share one interface.
  assign cpu_err = 1'b0 && (TIMEOUT_CYCLES != 0);
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (cpu_req) w_next = cpu_we ? S_WR_CACHE : S_LOOKUP;
      S_LOOKUP:   w_next = c_hit ? S_RESP : S_MEM_RD;
      S_MEM_RD: begin
        if (m_ack)      w_next = S_FILL;
        else if (w_tmo) w_next = S_RESP;
      end
      S_FILL:     w_next = S_RESP;
      S_WR_CACHE: w_next = S_MEM_WR;
      S_MEM_WR:   if (m_ack || w_tmo) w_next = S_RESP;
      S_RESP:     w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  // Request latch and read/fill data registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_cwdata <= '0;
    end else begin
      if (w_accept) begin
        r_addr  <= cpu_addr;
        r_wdata <= cpu_wdata;
        if (cpu_we) r_cwdata <= cpu_wdata;
      end
      if ((r_state == S_LOOKUP) && c_hit) begin
        r_rdata <= c_rdata;
      end
      if ((r_state == S_MEM_RD) && m_ack) begin
        r_rdata  <= m_rdata;
        r_cwdata <= m_rdata;
      end
    end
  end

  // The cache is registered, so the lookup strobe must be issued in the
  // accept cycle with the live CPU address; afterwards the latched address
  // is presented. Reset gating keeps c_rd low while reset is asserted.
  assign c_rd        = w_accept && !cpu_we && !reset;
  assign c_addr      = c_rd ? cpu_addr : r_addr;
  assign c_wr        = (r_state == S_FILL) || (r_state == S_WR_CACHE);
  assign c_wdata     = r_cwdata;

  assign cpu_ready   = (r_state == S_IDLE);
  assign cpu_done    = (r_state == S_RESP);
  assign cpu_rdata   = r_rdata;

  assign m_req       = w_mem_wait;
  assign m_we        = (r_state == S_MEM_WR);
  assign m_addr      = {r_addr[31:2], 2'b00};
  assign m_wdata     = r_wdata;

  assign o_dbg_state = r_state;

endmodule
